// File: rtl/bpu_resolve.sv
// Branch resolution and BHT feedback: queues IF predictions in order, checks each
// against the EX-resolved next PC, drives BHT updates and flush/redirect on a mispredict.
module bpu_resolve #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc_4,
  input  logic [1:0]        fetch_state,
  input  logic [ADDR_W-1:0] fetch_new_pc,
  input  logic              res_valid,
  input  logic              res_is_branch,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  output logic              upd_en,
  output logic [ADDR_W-1:0] upd_pc_4,
  output logic [ADDR_W-1:0] upd_pc_remote,
  output logic [1:0]        upd_state_old,
  output logic              upd_succ,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              full,
  output logic              empty,
  output logic [15:0]       mispred_cnt,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc_4;
    logic [1:0]        state;
    logic [ADDR_W-1:0] new_pc;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              upd_en_q;
  logic [ADDR_W-1:0] upd_pc_4_q, upd_pc_remote_q;
  logic [1:0]        upd_state_old_q;
  logic              upd_succ_q;
  logic              flush_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              full_q, empty_q;
  logic [15:0]       mispred_cnt_q, mispred_cnt_d;
  logic              err_q;

  entry_t            head;
  entry_t            fetch_entry;
  logic              q_full, q_empty;
  logic              accept, pop, push_req, push, mispred, err_set;
  logic [ADDR_W-1:0] actual;

  // Handshake: fetch_valid and res_valid are single-cycle strobes with no
  // back-pressure; a strobe that cannot be honoured is dropped and flags err,
  // except during the flush cycle where both are silently ignored.
  always_comb begin
    head        = mem_q[rd_q];
    fetch_entry = '{pc_4: fetch_pc_4, state: fetch_state, new_pc: fetch_new_pc};
    q_full      = (cnt_q == CW'(DEPTH));
    q_empty     = (cnt_q == '0);
    accept      = !flush_q;
    pop         = accept && res_valid && !q_empty;
    push_req    = accept && fetch_valid && (!q_full || res_valid);
    actual      = (res_is_branch && res_taken) ? res_target : head.pc_4;
    mispred     = pop && (actual != head.new_pc);
    push        = push_req && !mispred;
    err_set     = accept && ((res_valid && q_empty) || (fetch_valid && q_full && !res_valid));
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (mispred) begin
      // Everything younger than the mispredicted entry is wrong-path.
      rd_d  = wr_q;
      cnt_d = '0;
    end else begin
      if (pop)  rd_d = rd_q + 1'b1;
      if (push) wr_d = wr_q + 1'b1;
      cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (mispred && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= fetch_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q            <= '0;
      wr_q            <= '0;
      cnt_q           <= '0;
      upd_en_q        <= 1'b0;
      upd_pc_4_q      <= '0;
      upd_pc_remote_q <= '0;
      upd_state_old_q <= '0;
      upd_succ_q      <= 1'b0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      mispred_cnt_q   <= '0;
      err_q           <= 1'b0;
    end else begin
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      upd_en_q      <= pop && res_is_branch;
      flush_q       <= mispred;
      full_q        <= (cnt_d == CW'(DEPTH));
      empty_q       <= (cnt_d == '0);
      mispred_cnt_q <= mispred_cnt_d;
      err_q         <= err_q | err_set;
      if (pop && res_is_branch) begin
        upd_pc_4_q      <= head.pc_4;
        upd_pc_remote_q <= res_target;
        upd_state_old_q <= head.state;
        upd_succ_q      <= res_taken;
      end
      if (mispred) redirect_pc_q <= actual;
    end
  end

  assign upd_en        = upd_en_q;
  assign upd_pc_4      = upd_pc_4_q;
  assign upd_pc_remote = upd_pc_remote_q;
  assign upd_state_old = upd_state_old_q;
  assign upd_succ      = upd_succ_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_pc_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign mispred_cnt   = mispred_cnt_q;
  assign err           = err_q;

endmodule

// File: doc/bpu_resolve.md
# bpu_resolve

Branch resolution and BHT feedback unit for the pipelined core. Records every prediction consumed in IF in an in-order queue, retires each entry when EX resolves the matching instruction, and compares the predicted next PC against the actual next PC. For conditional branches it drives the BHT update port. On a mispredict it issues a one-cycle flush plus redirect PC to IF.

## Interface
- ADDR_W, 10, instruction-memory word-address width; equals `IM_ADDR_BIT`
- DEPTH, 4, queue entries (power of two, ≥2); covers the IF→EX distance
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- fetch_valid  in  1  IF consumed a prediction this cycle (push)
- fetch_pc_4  in  ADDR_W  PC+4 of the fetched instruction
- fetch_state  in  2  BHT guess_state for that fetch
- fetch_new_pc  in  ADDR_W  BHT guess_new_pc for that fetch
- res_valid  in  1  EX resolves the oldest queued instruction (pop)
- res_is_branch  in  1  resolved instruction is a conditional branch
- res_taken  in  1  branch outcome
- res_target  in  ADDR_W  branch target (ignored when !res_is_branch)
- upd_en  out  1  BHT update strobe
- upd_pc_4, upd_pc_remote  out  ADDR_W  BHT update key / target
- upd_state_old  out  2  state recorded at prediction
- upd_succ  out  1  actual outcome (1 = taken)
- flush  out  1  kill wrong-path IF/ID
- redirect_pc  out  ADDR_W  correct next PC, valid while flush=1
- full, empty  out  1  queue status
- mispred_cnt  out  16  saturating mispredict count
- err  out  1  sticky protocol error

## Operation
- Queue: circular buffer with rd/wr pointers and count (width log2(DEPTH)+1). Each entry holds {pc_4, state, new_pc}.
- Push when fetch_valid && (!full || res_valid). Push+pop in the same cycle is legal when full; count stays unchanged.
- Pop when res_valid && !empty. A pop on an empty queue is ignored and sets err. fetch_valid while full without a pop is dropped and sets err. err clears only on reset.
- Resolve the head entry E:
  - actual = (res_is_branch && res_taken) ? res_target : E.pc_4
  - mispredict = (actual != E.new_pc)
- Branch: upd_en=1, upd_pc_4=E.pc_4, upd_pc_remote=res_target, upd_state_old=E.state, upd_succ=res_taken.
- Non-branch: no BHT update. A mispredict is still possible because the BHT can alias taken onto a non-branch; it is handled as below.
- Mispredict:
  - Queue clears (rd=wr, count=0), and any push in the same cycle is discarded.
  - flush=1, redirect_pc=actual.
  - mispred_cnt increments, saturating at 16'hFFFF.
- Flush cycle: fetch_valid and res_valid are ignored (wrong-path or bubble). err is not set.

## Timing
- Reset values: upd_en=0, upd_pc_4=0, upd_pc_remote=0, upd_state_old=0, upd_succ=0, flush=0, redirect_pc=0, full=0, empty=1, mispred_cnt=0, err=0. Queue pointers and count are 0.
- All outputs are registered.
  - Resolution in cycle N gives upd_* and flush/redirect_pc valid in cycle N+1, each as a single-cycle pulse.
  - full/empty reflect the count after the edge.
- Mispredict at N: queue is empty at N+1, flush high only at N+1, normal push/pop resumes at N+2.
- Back-to-back resolutions with no mispredict produce consecutive upd_en pulses with no bubble.
- Reset asserted mid-operation clears the queue and all outputs immediately (asynchronous). No update or flush is emitted for in-flight entries.

## Test plan
- Reset, then push {pc_4=0x004, state=2'b00, new_pc=0x004}; resolve branch not-taken → N+1: upd_en=1, upd_pc_4=0x004, upd_state_old=00, upd_succ=0, flush=0, empty=1.
- Push {0x010, 2'b00, 0x010}; resolve branch taken, target 0x040 → upd_succ=1, upd_pc_remote=0x040, flush=1, redirect_pc=0x040, mispred_cnt=1.
- Push 3 entries, then mispredict the first with a same-cycle push → N+1: empty=1, flush=1. A fetch_valid in N+1 is dropped; a push in N+2 gives count=1.
- Fill DEPTH=4 → full=1. A 5th push alone sets err=1. Push+pop together while full keeps full=1, count=4, err unchanged.
- Non-branch with head {0x020, 2'b11, 0x080}, res_is_branch=0 → upd_en=0, flush=1, redirect_pc=0x020.
- Preload mispred_cnt to 0xFFFF via repeated mispredicts → holds 0xFFFF. Assert rst_n low mid-stream → all outputs return to reset values without waiting for clk.
